// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential carry-lookahead adder:
// controller states, the slice width and the packed result-flag bundle.
package cla_pkg;

    // Width of one lookahead slice; the adder walks the operands in steps of this.
    localparam int SLICE_W = 4;

    // Controller states: waiting for operands, walking slices, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result flags, kept together so they are registered and held as one unit.
    typedef struct packed {
        logic sign;
        logic carry;
        logic parity;
        logic zero;
        logic overflow;
    } flags_t;

    // Flag value used at reset and before any result exists.
    localparam flags_t FLAGS_CLEAR = '{sign: 1'b0, carry: 1'b0, parity: 1'b0,
                                       zero: 1'b0, overflow: 1'b0};

endpackage : cla_pkg

// File: rtl/cla_adder_seq_if.sv
// Operand/result handshake bundle for cla_adder_seq. The master side supplies
// operands and accepts results; the slave side is the adder itself.
interface cla_adder_seq_if #(
    parameter int WIDTH = 16
);

    // Operand channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             sign;
    logic             carry;
    logic             parity;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, x, y, cin, sub, out_ready,
        input  in_ready, out_valid, z, sign, carry, parity, zero, overflow
    );

    modport slave (
        input  in_valid, x, y, cin, sub, out_ready,
        output in_ready, out_valid, z, sign, carry, parity, zero, overflow
    );

endinterface : cla_adder_seq_if

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice. Every internal carry is a flat
// sum-of-products of generate/propagate terms and the slice carry-in, so no
// carry ripples through the slice. c3 (carry into bit 3) is exported so the
// caller can form two's-complement overflow on the most significant slice.
module cla_slice4
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co,
    output logic               c3
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic               c1;
    logic               c2;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries, all derived directly from ci.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule : cla_slice4

// File: rtl/cla_adder_seq.sv
// Sequential add/subtract unit. One cla_slice4 is time-multiplexed across the
// operands, one 4-bit slice per cycle, LSB first; the slice carry-out is held
// in a running-carry register between cycles. A result and its flags are held
// until the consumer takes them.
module cla_adder_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 16   // multiple of 4, at least 8
) (
    input  logic              clk,
    input  logic              rst_n,
    cla_adder_seq_if.slave    bus
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = $clog2(NSLICE);
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    // Controller
    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               last_slice;

    // Datapath state
    logic [WIDTH-1:0]   a_q;        // captured X
    logic [WIDTH-1:0]   b_q;        // effective B: Y for add, ~Y for subtract
    logic               carry_q;    // running carry into the current slice
    logic [CNT_W-1:0]   cnt_q;      // index of the slice being processed
    logic [WIDTH-1:0]   z_q;
    flags_t             flags_q;

    // Slice datapath
    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] s_slice;
    logic               co_slice;
    logic               c3_slice;
    logic [WIDTH-1:0]   z_next;
    flags_t             flags_next;

    // in_ready is gated by rst_n so it reads 0 for the whole reset window,
    // even though the state register already sits in IDLE.
    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);

    assign accept     = bus.in_valid && bus.in_ready;
    assign last_slice = (cnt_q == LAST_SLICE);

    // Select the operand nibbles for the slice currently being processed.
    assign a_slice = a_q[cnt_q * SLICE_W +: SLICE_W];
    assign b_slice = b_q[cnt_q * SLICE_W +: SLICE_W];

    cla_slice4 u_slice (
        .a  (a_slice),
        .b  (b_slice),
        .ci (carry_q),
        .s  (s_slice),
        .co (co_slice),
        .c3 (c3_slice)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, walk slices in BUSY, hold in DONE.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)        state_d = BUSY;
            BUSY:    if (last_slice)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Result as it will look once the current slice is written, plus the
    // flags derived from it; only committed on the final slice.
    always_comb begin
        z_next = z_q;
        z_next[cnt_q * SLICE_W +: SLICE_W] = s_slice;

        flags_next          = FLAGS_CLEAR;
        flags_next.sign     = z_next[WIDTH-1];
        flags_next.carry    = co_slice;
        flags_next.parity   = ~(^z_next);
        flags_next.zero     = (z_next == '0);
        flags_next.overflow = c3_slice ^ co_slice;
    end

    // Operand capture on accept; slice-by-slice result build in BUSY.
    // Operands are only written in IDLE, so they are frozen for the whole
    // operation regardless of what the producer does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            z_q     <= '0;
            flags_q <= FLAGS_CLEAR;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.x;
                        // Subtract is X + ~Y + 1; the caller's cin is ignored.
                        b_q     <= bus.sub ? ~bus.y : bus.y;
                        carry_q <= bus.sub ? 1'b1 : bus.cin;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    z_q     <= z_next;
                    carry_q <= co_slice;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_slice) begin
                        flags_q <= flags_next;
                    end
                end
                DONE: begin
                    // Result and flags held until the consumer accepts.
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.z        = z_q;
    assign bus.sign     = flags_q.sign;
    assign bus.carry    = flags_q.carry;
    assign bus.parity   = flags_q.parity;
    assign bus.zero     = flags_q.zero;
    assign bus.overflow = flags_q.overflow;

endmodule : cla_adder_seq

// File: tb/tb_cla_adder_seq.sv
// Self-checking bench for cla_adder_seq (WIDTH=16): hand-computed vector
// table, randomized operations against a full-width reference model, a
// back-pressure sequence and a mid-operation reset.
module tb_cla_adder_seq;
    import cla_pkg::*;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;
    localparam int NVEC   = 10;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cla_adder_seq_if #(.WIDTH(WIDTH)) bus ();

    cla_adder_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [WIDTH-1:0] z;
        flags_t           f;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             cin;
        logic             sub;
        exp_t             e;
    } vec_t;

    exp_t   sb_q[$];
    vec_t   vecs[NVEC];
    flags_t act_f;
    int     n_checks = 0;
    int     n_fail   = 0;

    assign act_f = {bus.sign, bus.carry, bus.parity, bus.zero, bus.overflow};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic flags_t mkf(input logic s, input logic c, input logic p,
                                   input logic zf, input logic v);
        flags_t f;
        f.sign = s; f.carry = c; f.parity = p; f.zero = zf; f.overflow = v;
        return f;
    endfunction

    function automatic vec_t mkv(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic cin, input logic sub,
                                 input logic [WIDTH-1:0] z, input flags_t f);
        vec_t v;
        v.x = x; v.y = y; v.cin = cin; v.sub = sub; v.e.z = z; v.e.f = f;
        return v;
    endfunction

    // Reference: full-width arithmetic with an extra bit for the carry;
    // overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic cin, input logic sub);
        exp_t             r;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   s;
        b  = sub ? ~y : y;
        s  = {1'b0, x} + {1'b0, b} + (WIDTH+1)'(sub ? 1'b1 : cin);
        r.z          = s[WIDTH-1:0];
        r.f.sign     = r.z[WIDTH-1];
        r.f.carry    = s[WIDTH];
        r.f.parity   = ~(^r.z);
        r.f.zero     = (r.z == '0);
        r.f.overflow = (x[WIDTH-1] == b[WIDTH-1]) && (r.z[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, present one operand pair for one accepting edge and
    // record the expected result in the scoreboard.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic cin, input logic sub, input exp_t e);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.x        = x;
        bus.y        = y;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        step();
        sb_q.push_back(e);
        bus.in_valid = 1'b0;
    endtask

    // Called right after the accepting edge: measure latency, then pop and
    // compare the result, then let out_ready=1 retire it.
    task automatic collect(input string name);
        int   lat = 0;
        exp_t e;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(NSLICE));
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_scoreboard: got empty queue, required one entry", name);
        end else begin
            e = sb_q.pop_front();
            check({name, "_z"}, 32'(bus.z), 32'(e.z));
            check({name, "_flags"}, 32'(act_f), 32'(e.f));
        end
        step();
        check({name, "_out_valid_retired"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t held;
        exp_t next_e;

        // flags order: sign, carry, parity, zero, overflow
        vecs[0] = mkv(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, mkf(0, 0, 0, 0, 0));
        vecs[1] = mkv(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, mkf(0, 1, 1, 1, 0));
        vecs[2] = mkv(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, mkf(1, 0, 0, 0, 1));
        vecs[3] = mkv(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, mkf(0, 1, 0, 0, 1));
        vecs[4] = mkv(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, mkf(1, 0, 0, 0, 0));
        vecs[5] = mkv(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, mkf(0, 0, 1, 0, 0));
        vecs[6] = mkv(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, mkf(0, 1, 1, 1, 0));
        vecs[7] = mkv(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, mkf(0, 1, 1, 1, 1));
        vecs[8] = mkv(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, mkf(0, 0, 0, 0, 0));
        vecs[9] = mkv(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, mkf(1, 0, 1, 0, 0));

        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset state
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_z", 32'(bus.z), 32'd0);
        check("rst_flags", 32'(act_f), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub, vecs[i].e);
            collect($sformatf("vec%0d", i));
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 16; i++) begin
            logic [WIDTH-1:0] rx;
            logic [WIDTH-1:0] ry;
            logic             rc;
            logic             rs;
            rx = WIDTH'($urandom);
            ry = WIDTH'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(rx, ry, rc, rs, model(rx, ry, rc, rs));
            collect($sformatf("rand%0d", i));
        end

        // Back-pressure: in_valid held high with a different pair during
        // BUSY and DONE; out_ready low for 10 cycles.
        bus.out_ready = 1'b0;
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, model(16'h7FFF, 16'h0001, 1'b0, 1'b0));
        bus.x        = 16'hA5A5;
        bus.y        = 16'h0F0F;
        bus.cin      = 1'b0;
        bus.sub      = 1'b1;
        bus.in_valid = 1'b1;
        next_e       = model(16'hA5A5, 16'h0F0F, 1'b0, 1'b1);
        begin
            int lat = 0;
            while (bus.out_valid !== 1'b1 && lat < 50) begin
                step();
                lat++;
            end
            check("hold_latency", 32'(lat), 32'(NSLICE));
        end
        held = sb_q[0];
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("hold%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("hold%0d_z", i), 32'(bus.z), 32'(held.z));
            check($sformatf("hold%0d_flags", i), 32'(act_f), 32'(held.f));
        end
        bus.out_ready = 1'b1;
        step();
        check("hold_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("hold_release_out_valid", 32'(bus.out_valid), 32'd0);
        void'(sb_q.pop_front());
        step();
        sb_q.push_back(next_e);
        bus.in_valid = 1'b0;
        collect("held_next");

        // Reset during slice 2 of an operation
        send(16'h1234, 16'h4321, 1'b1, 1'b0, model(16'h1234, 16'h4321, 1'b1, 1'b0));
        collect("pre_abort");
        send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("abort_z", 32'(bus.z), 32'd0);
        check("abort_flags", 32'(act_f), 32'd0);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        void'(sb_q.pop_back());
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("abort_release_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("abort_quiet%0d_out_valid", i), 32'(bus.out_valid), 32'd0);
        end
        send(16'h8000, 16'h0001, 1'b0, 1'b1, vecs[3].e);
        collect("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cla_adder_seq
